id_stage: RTL and testbench

//  Instruction-decode stage; sits between IF/ID latch (fetch) and ID/EX (execute) of the SimpleRisc pipeline.

---
 rtl/id_stage.sv | 172 +++++++++++++++++
 tb/tb_id_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// SimpleRisc instruction-decode stage: register file, immediate extension, type classification,
// load-use / write-back hazard stalls, flush squash and sticky HLT. Optional WB_BYPASS_EN forwards WB data.
module id_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk1,
    input  logic            rst,
    input  logic [31:0]     if_id_ir,
    input  logic [XLEN-1:0] if_id_npc,
    input  logic            if_id_valid,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic [31:0]     id_ex_ir,
    output logic [XLEN-1:0] id_ex_npc,
    output logic [XLEN-1:0] id_ex_a,
    output logic [XLEN-1:0] id_ex_b,
    output logic [XLEN-1:0] id_ex_imm,
    output logic [2:0]      id_ex_type,
    output logic            id_ex_valid,
    output logic            halted
);

    typedef enum logic [2:0] {
        T_RR     = 3'd0,
        T_RM     = 3'd1,
        T_LOAD   = 3'd2,
        T_STORE  = 3'd3,
        T_BRANCH = 3'd4,
        T_HALT   = 3'd5
    } itype_t;

    logic [XLEN-1:0] r_rf [NREG];

    logic [31:0]     r_id_ex_ir;
    logic [XLEN-1:0] r_id_ex_npc;
    logic [XLEN-1:0] r_id_ex_a;
    logic [XLEN-1:0] r_id_ex_b;
    logic [XLEN-1:0] r_id_ex_imm;
    itype_t          r_id_ex_type;
    logic            r_id_ex_valid;
    logic            r_halted;

    logic [5:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_ld_rd;
    itype_t          w_type;
    logic            w_known;
    logic            w_use_rs;
    logic            w_use_rt;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_imm;
    logic            w_load_use;
    logic            w_wb_haz;
    logic            w_stall;

    assign w_op    = if_id_ir[31:26];
    assign w_rs    = if_id_ir[25:21];
    assign w_rt    = if_id_ir[20:16];
    assign w_imm   = {{(XLEN-16){if_id_ir[15]}}, if_id_ir[15:0]};
    assign w_ld_rd = r_id_ex_ir[20:16];

    always_comb begin
        w_type   = T_RR;
        w_known  = 1'b1;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        case (w_op)
            6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05: begin
                w_type   = T_RR;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            6'h0A, 6'h0B, 6'h0C: begin
                w_type   = T_RM;
                w_use_rs = 1'b1;
            end
            6'h08: begin
                w_type   = T_LOAD;
                w_use_rs = 1'b1;
            end
            6'h09: begin
                w_type   = T_STORE;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            6'h0D, 6'h0E: begin
                w_type   = T_BRANCH;
                w_use_rs = 1'b1;
            end
            6'h3F: begin
                w_type = T_HALT;
            end
            default: begin
                w_type  = T_RR;
                w_known = 1'b0;
            end
        endcase
    end

    // R0 is held at zero by never enabling its write.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            always_ff @(posedge clk1) begin
                if (rst) begin
                    r_rf[gi] <= '0;
                end else if (gi != 0 && wb_en && wb_rd == 5'(gi)) begin
                    r_rf[gi] <= wb_data;
                end
            end
        end
    endgenerate

`ifdef WB_BYPASS_EN
    assign w_a      = (wb_en && wb_rd != 5'd0 && wb_rd == w_rs) ? wb_data : r_rf[w_rs];
    assign w_b      = (wb_en && wb_rd != 5'd0 && wb_rd == w_rt) ? wb_data : r_rf[w_rt];
    assign w_wb_haz = 1'b0;
`else
    assign w_a      = r_rf[w_rs];
    assign w_b      = r_rf[w_rt];
    // Without forwarding, wait one cycle for the write to commit.
    assign w_wb_haz = if_id_valid && wb_en && wb_rd != 5'd0 &&
                      ((w_use_rs && wb_rd == w_rs) || (w_use_rt && wb_rd == w_rt));
`endif

    assign w_load_use = if_id_valid && r_id_ex_valid && r_id_ex_type == T_LOAD && w_ld_rd != 5'd0 &&
                        ((w_use_rs && w_ld_rd == w_rs) || (w_use_rt && w_ld_rd == w_rt));

    assign w_stall = !rst && !flush && !r_halted && (w_load_use || w_wb_haz);

    always_ff @(posedge clk1) begin
        if (rst || flush || r_halted || w_stall) begin
            r_id_ex_ir    <= '0;
            r_id_ex_npc   <= '0;
            r_id_ex_a     <= '0;
            r_id_ex_b     <= '0;
            r_id_ex_imm   <= '0;
            r_id_ex_type  <= T_RR;
            r_id_ex_valid <= 1'b0;
            if (rst) begin
                r_halted <= 1'b0;
            end
        end else begin
            r_id_ex_ir    <= if_id_ir;
            r_id_ex_npc   <= if_id_npc;
            r_id_ex_a     <= w_a;
            r_id_ex_b     <= w_b;
            r_id_ex_imm   <= w_imm;
            r_id_ex_type  <= w_type;
            r_id_ex_valid <= if_id_valid && w_known;
            if (if_id_valid && w_type == T_HALT) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign stall       = w_stall;
    assign id_ex_ir    = r_id_ex_ir;
    assign id_ex_npc   = r_id_ex_npc;
    assign id_ex_a     = r_id_ex_a;
    assign id_ex_b     = r_id_ex_b;
    assign id_ex_imm   = r_id_ex_imm;
    assign id_ex_type  = r_id_ex_type;
    assign id_ex_valid = r_id_ex_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table through a scoreboard queue, plus reset sequences.
module tb_id_stage;

    logic        clk1 = 1'b0;
    logic        rst;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    logic        if_id_valid;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] id_ex_ir;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_a;
    logic [31:0] id_ex_b;
    logic [31:0] id_ex_imm;
    logic [2:0]  id_ex_type;
    logic        id_ex_valid;
    logic        halted;

    id_stage dut (
        .clk1(clk1), .rst(rst),
        .if_id_ir(if_id_ir), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .id_ex_ir(id_ex_ir), .id_ex_npc(id_ex_npc),
        .id_ex_a(id_ex_a), .id_ex_b(id_ex_b), .id_ex_imm(id_ex_imm),
        .id_ex_type(id_ex_type), .id_ex_valid(id_ex_valid), .halted(halted)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] npc;
        logic        valid;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        e_stall;
        logic        e_valid;
        logic [2:0]  e_type;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_imm;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rt, logic [4:0] rs, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] ir, input logic valid, input logic fl,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic e_stall, input logic e_valid, input logic [2:0] e_type,
                       input logic [31:0] e_a, input logic [31:0] e_b, input logic e_halt);
        vec_t v;
        v.ir = ir;  v.npc = 32'h1000 + 32'(vecs.size());
        v.valid = valid; v.flush = fl; v.wb_en = we; v.wb_rd = wrd; v.wb_data = wd;
        v.e_stall = e_stall; v.e_valid = e_valid; v.e_type = e_type;
        v.e_a = e_a; v.e_b = e_b; v.e_imm = {{16{ir[15]}}, ir[15:0]}; v.e_halt = e_halt;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    logic [31:0] add312, addi4, lw5, add6, lw0, add6r0, lw5b, sw5, beqz, add7, unk, add8, hlt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vec_t e;
        rst = 1'b1; if_id_ir = '0; if_id_npc = '0; if_id_valid = 1'b0;
        flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;

        add312 = enc_r(6'h00, 5'd3, 5'd1, 5'd2);
        addi4  = enc_i(6'h0A, 5'd4, 5'd0, 16'hFFFF);
        lw5    = enc_i(6'h08, 5'd5, 5'd1, 16'h0000);
        add6   = enc_r(6'h00, 5'd6, 5'd5, 5'd2);
        lw0    = enc_i(6'h08, 5'd0, 5'd1, 16'h0000);
        add6r0 = enc_r(6'h00, 5'd6, 5'd0, 5'd2);
        lw5b   = enc_i(6'h08, 5'd5, 5'd2, 16'h0004);
        sw5    = enc_i(6'h09, 5'd5, 5'd1, 16'h0000);
        beqz   = enc_i(6'h0E, 5'd0, 5'd1, 16'hFFFE);
        add7   = enc_r(6'h00, 5'd7, 5'd1, 5'd2);
        unk    = enc_i(6'h20, 5'd0, 5'd0, 16'h0000);
        add8   = enc_r(6'h00, 5'd8, 5'd0, 5'd0);
        hlt    = enc_i(6'h3F, 5'd0, 5'd0, 16'h0000);

        //   ir      vld fl we rd   data          stall vld type a         b         halt
        add(32'h0,  0, 0, 1, 5'd1, 32'h5,        0, 0, 3'd0, 32'h0, 32'h0, 0);
        add(32'h0,  0, 0, 1, 5'd2, 32'h7,        0, 0, 3'd0, 32'h0, 32'h0, 0);
        add(add312, 1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd0, 32'h5, 32'h7, 0);
        add(addi4,  1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd1, 32'h0, 32'h0, 0);
        add(lw5,    1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd2, 32'h5, 32'h0, 0);
        add(add6,   1, 0, 0, 5'd0, 32'h0,        1, 0, 3'd0, 32'h0, 32'h0, 0);
        add(add6,   1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd0, 32'h0, 32'h7, 0);
        add(lw0,    1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd2, 32'h5, 32'h0, 0);
        add(add6r0, 1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd0, 32'h0, 32'h7, 0);
        add(lw5b,   1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd2, 32'h7, 32'h0, 0);
        add(sw5,    1, 0, 0, 5'd0, 32'h0,        1, 0, 3'd0, 32'h0, 32'h0, 0);
        add(sw5,    1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd3, 32'h5, 32'h0, 0);
        add(lw5,    1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd2, 32'h5, 32'h0, 0);
        add(add6,   1, 1, 0, 5'd0, 32'h0,        0, 0, 3'd0, 32'h0, 32'h0, 0);
        add(beqz,   1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd4, 32'h5, 32'h0, 0);
`ifdef WB_BYPASS_EN
        add(add7,   1, 0, 1, 5'd2, 32'h99,       0, 1, 3'd0, 32'h5, 32'h99, 0);
`else
        add(add7,   1, 0, 1, 5'd2, 32'h99,       1, 0, 3'd0, 32'h0, 32'h0, 0);
`endif
        add(add7,   1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd0, 32'h5, 32'h99, 0);
        add(unk,    1, 0, 0, 5'd0, 32'h0,        0, 0, 3'd0, 32'h0, 32'h0, 0);
        add(add8,   1, 0, 1, 5'd0, 32'h1234,     0, 1, 3'd0, 32'h0, 32'h0, 0);
        add(add8,   1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd0, 32'h0, 32'h0, 0);
        add(lw5,    0, 0, 0, 5'd0, 32'h0,        0, 0, 3'd0, 32'h0, 32'h0, 0);
        add(hlt,    1, 0, 0, 5'd0, 32'h0,        0, 1, 3'd5, 32'h0, 32'h0, 1);
        add(add312, 1, 0, 0, 5'd0, 32'h0,        0, 0, 3'd0, 32'h0, 32'h0, 1);
        add(add7,   1, 0, 1, 5'd1, 32'h55,       0, 0, 3'd0, 32'h0, 32'h0, 1);

        // Reset state.
        step();
        step();
        chk("rst_stall", 0, 32'(stall), 32'h0);
        chk("rst_valid", 0, 32'(id_ex_valid), 32'h0);
        chk("rst_halted", 0, 32'(halted), 32'h0);
        chk("rst_ir", 0, id_ex_ir, 32'h0);
        chk("rst_npc", 0, id_ex_npc, 32'h0);
        chk("rst_a", 0, id_ex_a, 32'h0);
        chk("rst_b", 0, id_ex_b, 32'h0);
        chk("rst_imm", 0, id_ex_imm, 32'h0);
        chk("rst_type", 0, 32'(id_ex_type), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if_id_ir = v.ir; if_id_npc = v.npc; if_id_valid = v.valid; flush = v.flush;
            wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
            #1;
            chk("stall", i, 32'(stall), 32'(v.e_stall));
            sb.push_back(v);
            step();
            e = sb.pop_front();
            chk("valid", i, 32'(id_ex_valid), 32'(e.e_valid));
            chk("halted", i, 32'(halted), 32'(e.e_halt));
            if (e.e_valid) begin
                chk("type", i, 32'(id_ex_type), 32'(e.e_type));
                chk("a", i, id_ex_a, e.e_a);
                chk("b", i, id_ex_b, e.e_b);
                chk("imm", i, id_ex_imm, e.e_imm);
                chk("ir", i, id_ex_ir, e.ir);
                chk("npc", i, id_ex_npc, e.npc);
            end
            if (e.e_stall) begin
                chk("bubble_ir", i, id_ex_ir, 32'h0);
            end
            $display("vec %0d: ir=%h stall=%b valid=%b type=%0d a=%h b=%h imm=%h halted=%b",
                     i, v.ir, v.e_stall, id_ex_valid, id_ex_type, id_ex_a, id_ex_b, id_ex_imm, halted);
        end

        // Reset clears halt and the register file, then rst while a load-use stall is pending.
        wb_en = 1'b0; flush = 1'b0; if_id_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("seq_halt_clear", 100, 32'(halted), 32'h0);
        if_id_ir = lw5; if_id_npc = 32'h2000; if_id_valid = 1'b1;
        step();
        chk("seq_lw_valid", 101, 32'(id_ex_valid), 32'h1);
        chk("seq_lw_a", 101, id_ex_a, 32'h0);
        if_id_ir = add6; if_id_npc = 32'h2001;
        #1;
        chk("seq_pre_stall", 102, 32'(stall), 32'h1);
        rst = 1'b1;
        #1;
        chk("seq_rst_stall", 102, 32'(stall), 32'h0);
        step();
        chk("seq_rst_valid", 102, 32'(id_ex_valid), 32'h0);
        chk("seq_rst_ir", 102, id_ex_ir, 32'h0);
        rst = 1'b0;
        #1;
        chk("seq_post_stall", 103, 32'(stall), 32'h0);
        step();
        chk("seq_post_valid", 103, 32'(id_ex_valid), 32'h1);
        chk("seq_post_b", 103, id_ex_b, 32'h0);
        chk("seq_post_npc", 103, id_ex_npc, 32'h2001);
        $display("seq reset-mid-stall: valid=%b a=%h b=%h halted=%b", id_ex_valid, id_ex_a, id_ex_b, halted);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
